// File: rtl/ex_mem_reg_pkg.sv
// Shared WISC definitions: opcodes, flag bit positions, word type and the EX/MEM register layout.
// Also holds the opcode -> flag write-mask decode used by the flag unit.
package wisc_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       halt;
    logic [3:0] opcode;
    word_t      alu_result;
    word_t      store_data;
    logic [3:0] rd;
  } mem_stage_t;

  // ADD/SUB write all three flags; logic/shift ops write Z only; everything else writes none.
  function automatic logic [2:0] flag_wr_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX -> MEM pipeline bus: EX-side instruction fields in, registered MEM fields and flags out.
// master drives the EX side, slave is the pipeline register.
interface ex_mem_reg_if;
  import wisc_pkg::*;

  logic       ex_valid;
  logic [3:0] ex_opcode;
  word_t      ex_alu_result;
  logic       ex_ovfl;
  word_t      ex_store_data;
  logic [3:0] ex_rd;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic       ex_mem_write;

  logic       mem_valid;
  logic       mem_reg_write;
  logic       mem_mem_read;
  logic       mem_mem_write;
  logic       mem_halt;
  logic [3:0] mem_opcode;
  word_t      mem_alu_result;
  word_t      mem_store_data;
  logic [3:0] mem_rd;

  logic       flag_z;
  logic       flag_v;
  logic       flag_n;

  modport master (
    output ex_valid, ex_opcode, ex_alu_result, ex_ovfl, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write,
    input  mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt,
           mem_opcode, mem_alu_result, mem_store_data, mem_rd,
           flag_z, flag_v, flag_n
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_alu_result, ex_ovfl, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write,
    output mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt,
           mem_opcode, mem_alu_result, mem_store_data, mem_rd,
           flag_z, flag_v, flag_n
  );

endinterface

// File: rtl/ex_mem_reg_flag_unit.sv
// Z/V/N flag register with per-bit write enables decoded from the advancing opcode.
// EXMEM_FLAG_FWD_EN: outputs show the next-state flags combinationally; otherwise the registered flags.
module flag_unit
  import wisc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv_i,
  input  logic [3:0] opcode_i,
  input  word_t      result_i,
  input  logic       ovfl_i,
  output logic [2:0] flags_o
);

  logic [2:0] flags_q, flags_d;
  logic [2:0] we;
  logic [2:0] val;

  always_comb begin
    we           = adv_i ? flag_wr_mask(opcode_i) : 3'b000;
    val          = 3'b000;
    val[FLAG_Z]  = (result_i == 16'h0000);
    val[FLAG_N]  = result_i[15];
    val[FLAG_V]  = ovfl_i;
    flags_d      = (flags_q & ~we) | (val & we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

`ifdef EXMEM_FLAG_FWD_EN
  // Forwarded view must also reflect the reset that will land on this edge.
  assign flags_o = rst ? 3'b000 : flags_d;
`else
  assign flags_o = flags_q;
`endif

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, sticky halt and the architectural flag unit.
// Optional macro EXMEM_FLAG_FWD_EN forwards next-state flags combinationally.
module ex_mem_reg
  import wisc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  ex_mem_reg_if.slave  bus
);

  mem_stage_t mem_q, mem_d;
  logic       adv;
  logic [2:0] flags;

  assign adv = bus.ex_valid & ~stall & ~flush;

  always_comb begin
    mem_d = mem_q;
    if (!stall && flush) begin
      mem_d.valid     = 1'b0;
      mem_d.reg_write = 1'b0;
      mem_d.mem_read  = 1'b0;
      mem_d.mem_write = 1'b0;
    end else if (!stall) begin
      mem_d.valid      = bus.ex_valid;
      mem_d.reg_write  = bus.ex_valid & bus.ex_reg_write;
      mem_d.mem_read   = bus.ex_valid & bus.ex_mem_read;
      mem_d.mem_write  = bus.ex_valid & bus.ex_mem_write;
      mem_d.halt       = mem_q.halt | (bus.ex_valid & (bus.ex_opcode == OP_HLT));
      mem_d.opcode     = bus.ex_opcode;
      mem_d.alu_result = bus.ex_alu_result;
      mem_d.store_data = bus.ex_store_data;
      mem_d.rd         = bus.ex_rd;
    end
  end

  // Halt is sticky: only reset clears it, so flush leaves mem_q.halt untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  flag_unit u_flag_unit (
    .clk      (clk),
    .rst      (rst),
    .adv_i    (adv),
    .opcode_i (bus.ex_opcode),
    .result_i (bus.ex_alu_result),
    .ovfl_i   (bus.ex_ovfl),
    .flags_o  (flags)
  );

  assign bus.mem_valid      = mem_q.valid;
  assign bus.mem_reg_write  = mem_q.reg_write;
  assign bus.mem_mem_read   = mem_q.mem_read;
  assign bus.mem_mem_write  = mem_q.mem_write;
  assign bus.mem_halt       = mem_q.halt;
  assign bus.mem_opcode     = mem_q.opcode;
  assign bus.mem_alu_result = mem_q.alu_result;
  assign bus.mem_store_data = mem_q.store_data;
  assign bus.mem_rd         = mem_q.rd;
  assign bus.flag_z         = flags[FLAG_Z];
  assign bus.flag_v         = flags[FLAG_V];
  assign bus.flag_n         = flags[FLAG_N];

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios then random traffic against a behavioural model.
module tb_ex_mem_reg;
  import wisc_pkg::*;

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic pre_n;
  int   n_cmp = 0;
  int   n_err = 0;

  ex_mem_reg_if bus ();

  ex_mem_reg dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid, rw, mr, mw, halt;
    logic [3:0] op;
    logic [15:0] res, sd;
    logic [3:0] rd;
    logic       known;
    logic       z, v, n;
  } mstate_t;

  mstate_t cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Next architectural state from the current inputs, straight from the stage rules.
  function automatic mstate_t model_next(input mstate_t s);
    mstate_t t;
    t = s;
    if (rst) begin
      t = '0;
      t.known = 1'b1;
    end else if (!stall) begin
      if (flush) begin
        t.valid = 1'b0; t.rw = 1'b0; t.mr = 1'b0; t.mw = 1'b0;
        t.known = 1'b0;
      end else begin
        t.valid = bus.ex_valid;
        t.rw    = bus.ex_valid && bus.ex_reg_write;
        t.mr    = bus.ex_valid && bus.ex_mem_read;
        t.mw    = bus.ex_valid && bus.ex_mem_write;
        t.halt  = s.halt || (bus.ex_valid && bus.ex_opcode == 4'hF);
        t.op    = bus.ex_opcode;
        t.res   = bus.ex_alu_result;
        t.sd    = bus.ex_store_data;
        t.rd    = bus.ex_rd;
        t.known = 1'b1;
        if (bus.ex_valid) begin
          if (bus.ex_opcode inside {4'h0, 4'h1}) begin
            t.z = (bus.ex_alu_result == 16'h0);
            t.n = bus.ex_alu_result[15];
            t.v = bus.ex_ovfl;
          end else if (bus.ex_opcode inside {4'h2, 4'h4, 4'h5, 4'h6}) begin
            t.z = (bus.ex_alu_result == 16'h0);
          end
        end
      end
    end
    return t;
  endfunction

  task automatic step(input logic r, input logic s, input logic f, input logic v,
                      input logic [3:0] op, input logic [15:0] res, input logic ov,
                      input logic rw, input logic mr, input logic mw);
    mstate_t nxt, fe;
    @(negedge clk);
    rst = r; stall = s; flush = f;
    bus.ex_valid      = v;
    bus.ex_opcode     = op;
    bus.ex_alu_result = res;
    bus.ex_ovfl       = ov;
    bus.ex_store_data = 16'($urandom);
    bus.ex_rd         = 4'($urandom);
    bus.ex_reg_write  = rw;
    bus.ex_mem_read   = mr;
    bus.ex_mem_write  = mw;
    #1;
    nxt = model_next(cur);
`ifdef EXMEM_FLAG_FWD_EN
    fe = nxt;
`else
    fe = cur;
`endif
    pre_n = bus.flag_n;
    check("pre_flag_z", bus.flag_z, fe.z);
    check("pre_flag_v", bus.flag_v, fe.v);
    check("pre_flag_n", bus.flag_n, fe.n);
    @(posedge clk);
    #1;
    cur = nxt;
    check("mem_valid", bus.mem_valid, cur.valid);
    check("mem_reg_write", bus.mem_reg_write, cur.rw);
    check("mem_mem_read", bus.mem_mem_read, cur.mr);
    check("mem_mem_write", bus.mem_mem_write, cur.mw);
    check("mem_halt", bus.mem_halt, cur.halt);
    if (cur.known) begin
      check("mem_opcode", bus.mem_opcode, cur.op);
      check("mem_alu_result", bus.mem_alu_result, cur.res);
      check("mem_store_data", bus.mem_store_data, cur.sd);
      check("mem_rd", bus.mem_rd, cur.rd);
    end
    check("flag_z", bus.flag_z, cur.z);
    check("flag_v", bus.flag_v, cur.v);
    check("flag_n", bus.flag_n, cur.n);
  endtask

  task automatic go(input logic s, input logic f, input logic [3:0] op,
                    input logic [15:0] res, input logic ov);
    step(1'b0, s, f, 1'b1, op, res, ov, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    cur = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_opcode = 4'h0; bus.ex_alu_result = 16'h0;
    bus.ex_ovfl = 1'b0; bus.ex_store_data = 16'h0; bus.ex_rd = 4'h0;
    bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0;
    do_reset();
    do_reset();
    check("rst_valid", bus.mem_valid, 0);
    check("rst_opcode", bus.mem_opcode, 0);
    check("rst_flags", {bus.flag_z, bus.flag_v, bus.flag_n}, 3'b000);

    // ADD 0x7FFF with overflow
    go(1'b0, 1'b0, 4'h0, 16'h7FFF, 1'b1);
    check("add_7fff_z", bus.flag_z, 0);
    check("add_7fff_n", bus.flag_n, 0);
    check("add_7fff_v", bus.flag_v, 1);
    check("add_7fff_res", bus.mem_alu_result, 16'h7FFF);

    // Z=0 N=1 V=1, then PADDSB must not touch flags
    go(1'b0, 1'b0, 4'h0, 16'h8000, 1'b1);
    go(1'b0, 1'b0, 4'h7, 16'h7777, 1'b0);
    check("paddsb_flags", {bus.flag_z, bus.flag_n, bus.flag_v}, 3'b011);
    check("paddsb_op", bus.mem_opcode, 4'h7);
    check("paddsb_res", bus.mem_alu_result, 16'h7777);

    // XOR zero result: Z only
    go(1'b0, 1'b0, 4'h2, 16'h0000, 1'b0);
    check("xor_flags", {bus.flag_z, bus.flag_n, bus.flag_v}, 3'b111);

    // Stall dominates flush for three cycles, then SUB zero lands
    go(1'b0, 1'b0, 4'h0, 16'h0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      go(1'b1, 1'b1, 4'h1, 16'h0000, 1'b0);
      check("stall_hold_z", bus.flag_z, 0);
      check("stall_hold_op", bus.mem_opcode, 4'h0);
      check("stall_hold_valid", bus.mem_valid, 1);
      check("stall_hold_res", bus.mem_alu_result, 16'h0001);
    end
    go(1'b0, 1'b0, 4'h1, 16'h0000, 1'b0);
    check("sub_release_z", bus.flag_z, 1);
    check("sub_release_op", bus.mem_opcode, 4'h1);

    // Sticky halt
    go(1'b0, 1'b0, 4'hF, 16'h0000, 1'b0);
    check("hlt_halt", bus.mem_halt, 1);
    go(1'b0, 1'b1, 4'h0, 16'h0000, 1'b0);
    check("hlt_flush_valid", bus.mem_valid, 0);
    check("hlt_flush_halt", bus.mem_halt, 1);
    go(1'b1, 1'b0, 4'h0, 16'h0005, 1'b0);
    go(1'b0, 1'b0, 4'h2, 16'h0005, 1'b0);
    check("hlt_sticky", bus.mem_halt, 1);
    do_reset();
    check("hlt_rst", bus.mem_halt, 0);

    // Flag forwarding timing on N
    go(1'b0, 1'b0, 4'h0, 16'h8000, 1'b0);
`ifdef EXMEM_FLAG_FWD_EN
    check("fwd_pre_n", pre_n, 1);
`else
    check("fwd_pre_n", pre_n, 0);
`endif
    check("fwd_post_n", bus.flag_n, 1);

    // Invalid EX with control bits set loads zero controls
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("inv_ctrl", {bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write}, 3'b000);

    // Reset mid-stall discards held instruction, next cycle accepts
    go(1'b0, 1'b0, 4'h0, 16'h0005, 1'b0);
    go(1'b1, 1'b0, 4'h1, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'h1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_stall_valid", bus.mem_valid, 0);
    check("rst_stall_op", bus.mem_opcode, 0);
    go(1'b0, 1'b0, 4'h2, 16'h0000, 1'b0);
    check("post_rst_valid", bus.mem_valid, 1);
    check("post_rst_z", bus.flag_z, 1);

    for (int i = 0; i < 500; i++) begin
      logic [15:0] r;
      r = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
           4'($urandom), r, 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
